// File: rtl/counter_to_32.sv
// counter_to_32: free-running step counter that flags its terminal value, sequencing the multiplier
// Holds at LAST or wraps to 0 depending on SATURATE; outputs are registered with no input-to-output path.
module counter_to_32 #(
    parameter int WIDTH    = 5,
    parameter int LAST     = 31,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count,
    output logic             reached
);
    if (LAST < 1 || LAST > (2 ** WIDTH) - 1) begin : g_bad_last
        $error("counter_to_32: LAST must satisfy 1 <= LAST <= 2**WIDTH-1");
    end
    localparam logic [WIDTH-1:0] LAST_W = WIDTH'(LAST);
    logic [WIDTH-1:0] next_count;
    always_comb begin
        next_count = (count == LAST_W) ? (SATURATE ? LAST_W : '0) : count + WIDTH'(1);
    end
    // reached is derived from next_count so it lands in the same edge as count
    always_ff @(posedge clk) begin
        if (!reset) begin
            count   <= '0;
            reached <= 1'b0;
        end else begin
            count   <= next_count;
            reached <= (next_count == LAST_W);
        end
    end
endmodule

// File: tb/tb_counter_to_32.sv
// tb_counter_to_32: directed and randomized checks of a saturating and a wrapping counter
// Reference model tracks the count as a plain integer following the counting rules.
module tb_counter_to_32;
    localparam int LAST = 31;
    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic [4:0] count_a, count_b;
    logic reached_a, reached_b;
    int model_a = 0;
    int model_b = 0;
    int passed = 0;
    int total = 0;
    int highs = 0;

    always #5 clk = ~clk;

    counter_to_32 #(.WIDTH(5), .LAST(LAST), .SATURATE(1'b1)) dut_a (
        .clk(clk), .reset(rst_a), .count(count_a), .reached(reached_a)
    );
    counter_to_32 #(.WIDTH(5), .LAST(LAST), .SATURATE(1'b0)) dut_b (
        .clk(clk), .reset(rst_b), .count(count_b), .reached(reached_b)
    );

    function automatic int next_model(int m, logic r, bit sat);
        if (!r) return 0;
        if (m < LAST) return m + 1;
        return sat ? LAST : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        model_a = next_model(model_a, rst_a, 1'b1);
        model_b = next_model(model_b, rst_b, 1'b0);
        #1;
        check("count_a", {27'd0, count_a}, model_a);
        check("reached_a", {31'd0, reached_a}, {31'd0, model_a == LAST});
        check("count_b", {27'd0, count_b}, model_b);
        check("reached_b", {31'd0, reached_b}, {31'd0, model_b == LAST});
    endtask

    initial begin
        repeat (3) begin
            tick();
            check("reset_count", {27'd0, count_a}, 32'd0);
            check("reset_reached", {31'd0, reached_a}, 32'd0);
        end
        rst_a = 1'b1;
        #2;
        rst_a = 1'b0;
        #1;
        check("between_edges_count", {27'd0, count_a}, 32'd0);
        check("between_edges_reached", {31'd0, reached_a}, 32'd0);
        rst_a = 1'b1;
        tick();
        check("first_edge_count", {27'd0, count_a}, 32'd1);
        repeat (29) tick();
        check("edge30_count", {27'd0, count_a}, 32'd30);
        check("edge30_reached", {31'd0, reached_a}, 32'd0);
        tick();
        check("edge31_count", {27'd0, count_a}, 32'd31);
        check("edge31_reached", {31'd0, reached_a}, 32'd1);
        repeat (10) begin
            tick();
            check("sat_count", {27'd0, count_a}, 32'd31);
            check("sat_reached", {31'd0, reached_a}, 32'd1);
        end
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
        repeat (17) tick();
        check("mid_count17", {27'd0, count_a}, 32'd17);
        rst_a = 1'b0;
        tick();
        check("mid_reset_count", {27'd0, count_a}, 32'd0);
        check("mid_reset_reached", {31'd0, reached_a}, 32'd0);
        rst_a = 1'b1;
        tick();
        check("restart_count", {27'd0, count_a}, 32'd1);
        repeat (40) tick();
        rst_a = 1'b0;
        tick();
        check("sat_reset_reached", {31'd0, reached_a}, 32'd0);
        rst_a = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            tick();
            check("resat_reached", {31'd0, reached_a}, {31'd0, i == 31});
        end
        rst_b = 1'b1;
        tick();
        repeat (30) tick();
        check("wrap_pre_count", {27'd0, count_b}, 32'd31);
        check("wrap_pre_reached", {31'd0, reached_b}, 32'd1);
        tick();
        check("wrap_count", {27'd0, count_b}, 32'd0);
        check("wrap_reached", {31'd0, reached_b}, 32'd0);
        highs = 0;
        repeat (96) begin
            tick();
            highs += int'(reached_b);
        end
        check("wrap_duty", highs, 32'd3);
        repeat (300) begin
            rst_a = ($urandom_range(15) != 0);
            rst_b = ($urandom_range(15) != 0);
            tick();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
